// File: rtl/phy_mdio_link_mgr.sv
// Clause-22 MDIO master: periodic PHY status poll plus host register
// access, decoding speed/duplex/link for the MAC and TX clock mux.
module phy_mdio_link_mgr #(
  parameter logic [4:0]  PHY_ADDR      = 5'd0,
  parameter logic [4:0]  STATUS_REG    = 5'd17,
  parameter int unsigned MDC_DIV       = 10,
  parameter int unsigned POLL_INTERVAL = 500000
) (
  input  logic        clk_50_max10,
  input  logic        fpga_resetn,
  output logic        enet_mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oen,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        link_up,
  output logic [1:0]  link_speed,
  output logic        full_duplex,
  output logic        set_1000,
  output logic        set_10,
  output logic        speed_change
);

  localparam int TW = $clog2(POLL_INTERVAL);
  localparam logic [TW-1:0] T_LAST = TW'(POLL_INTERVAL - 1);
  localparam logic [7:0]    D_LAST = 8'(MDC_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FRAME,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [TW-1:0] timer_q, timer_d;
  logic          poll_pend_q, poll_pend_d;
  logic          last_host_q, last_host_d;
  logic          host_q, host_d;
  logic          wr_q, wr_d;
  logic [7:0]    div_q, div_d;
  logic          hi_q, hi_d;
  logic [5:0]    bit_q, bit_d;
  logic [63:0]   sh_q, sh_d;
  logic [15:0]   rx_q, rx_d;
  logic          mdc_q, mdc_d;
  logic          out_q, out_d;
  logic          oen_q, oen_d;
  logic          link_q, link_d;
  logic [1:0]    spd_q, spd_d;
  logic          dup_q, dup_d;
  logic          s1000_q, s1000_d;
  logic          s10_q, s10_d;
  logic          chg_q, chg_d;

  logic        idle;
  logic        wrap;
  logic        div_end;
  logic        grant_poll;
  logic        grant_host;
  logic        frm_wr;
  logic [4:0]  frm_reg;
  logic [63:0] frame;

  assign idle    = (state_q == S_IDLE);
  assign wrap    = (timer_q == T_LAST);
  assign div_end = (div_q == D_LAST);

  // Alternate poll/host under contention so neither side starves
  assign req_ready  = fpga_resetn & idle & ~(poll_pend_q & last_host_q);
  assign grant_poll = idle & poll_pend_q & (~req_valid | last_host_q);
  assign grant_host = ~grant_poll & req_valid & req_ready;

  assign frm_wr  = grant_host & req_write;
  assign frm_reg = grant_host ? req_reg : STATUS_REG;
  assign frame   = {32'hFFFF_FFFF, 2'b01,
                    frm_wr ? 2'b01 : 2'b10,
                    PHY_ADDR, frm_reg,
                    frm_wr ? 2'b10 : 2'b11,
                    frm_wr ? req_wdata : 16'hFFFF};

  always_ff @(posedge clk_50_max10) begin
    if (!fpga_resetn) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      poll_pend_q <= 1'b0;
      last_host_q <= 1'b0;
      host_q      <= 1'b0;
      wr_q        <= 1'b0;
      div_q       <= '0;
      hi_q        <= 1'b0;
      bit_q       <= '0;
      sh_q        <= '0;
      rx_q        <= '0;
      mdc_q       <= 1'b0;
      out_q       <= 1'b1;
      oen_q       <= 1'b1;
      link_q      <= 1'b0;
      spd_q       <= 2'd1;
      dup_q       <= 1'b0;
      s1000_q     <= 1'b0;
      s10_q       <= 1'b0;
      chg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      poll_pend_q <= poll_pend_d;
      last_host_q <= last_host_d;
      host_q      <= host_d;
      wr_q        <= wr_d;
      div_q       <= div_d;
      hi_q        <= hi_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      rx_q        <= rx_d;
      mdc_q       <= mdc_d;
      out_q       <= out_d;
      oen_q       <= oen_d;
      link_q      <= link_d;
      spd_q       <= spd_d;
      dup_q       <= dup_d;
      s1000_q     <= s1000_d;
      s10_q       <= s10_d;
      chg_q       <= chg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (grant_poll || grant_host) state_d = S_FRAME;
      S_FRAME: if (hi_q && div_end && bit_q == 6'd63) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    timer_d     = wrap ? '0 : timer_q + 1'b1;
    poll_pend_d = grant_poll ? 1'b0 : (poll_pend_q | wrap);
    last_host_d = last_host_q;
    host_d      = host_q;
    wr_d        = wr_q;
    div_d       = div_q;
    hi_d        = hi_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    rx_d        = rx_q;
    mdc_d       = mdc_q;
    out_d       = out_q;
    oen_d       = oen_q;
    link_d      = link_q;
    spd_d       = spd_q;
    dup_d       = dup_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_poll || grant_host) begin
          last_host_d = grant_host;
          host_d      = grant_host;
          wr_d        = frm_wr;
          div_d       = '0;
          hi_d        = 1'b0;
          bit_d       = '0;
          sh_d        = frame;
          rx_d        = '0;
          mdc_d       = 1'b0;
          out_d       = frame[63];
          oen_d       = 1'b0;
        end
      end
      S_FRAME: begin
        div_d = div_end ? '0 : div_q + 8'd1;
        if (div_end && !hi_q) begin
          hi_d  = 1'b1;
          mdc_d = 1'b1;
          if (!wr_q && bit_q >= 6'd48) rx_d = {rx_q[14:0], mdio_in};
        end else if (div_end) begin
          hi_d  = 1'b0;
          mdc_d = 1'b0;
          if (bit_q == 6'd63) begin
            out_d = 1'b1;
            oen_d = 1'b1;
          end else begin
            bit_d = bit_q + 6'd1;
            sh_d  = {sh_q[62:0], sh_q[63]};
            out_d = sh_q[62];
            // Reads release the bus from the turnaround onwards
            oen_d = ~wr_q & (bit_q >= 6'd45);
          end
        end
      end
      S_DONE: begin
        if (!host_q && rx_q[11]) begin
          link_d = rx_q[10];
          dup_d  = rx_q[13];
          if (rx_q[15:14] != 2'b11) spd_d = rx_q[15:14];
        end
      end
      default: ;
    endcase
    s1000_d = (spd_d == 2'd2);
    s10_d   = (spd_d == 2'd0);
    chg_d   = (spd_d != spd_q);
  end

  assign enet_mdc     = mdc_q;
  assign mdio_out     = out_q;
  assign mdio_oen     = oen_q;
  assign rsp_valid    = (state_q == S_DONE) & host_q;
  assign rsp_rdata    = (rsp_valid & ~wr_q) ? rx_q : 16'h0000;
  assign link_up      = link_q;
  assign link_speed   = spd_q;
  assign full_duplex  = dup_q;
  assign set_1000     = s1000_q;
  assign set_10       = s10_q;
  assign speed_change = chg_q;

endmodule
